// File: rtl/typewriter_cursor_ctrl.sv
// Keystroke FIFO plus cursor engine that turns ASCII codes and control codes
// into character display RAM writes over a GRID_COL x GRID_ROW text grid.
module typewriter_cursor_ctrl #(
    parameter int GRID_COL         = 10,
    parameter int GRID_ROW         = 5,
    parameter int ASCII_WIDTH      = 8,
    parameter int ADDR_WIDTH       = 11,
    parameter int FIFO_DEPTH       = 4,
    parameter int TAB_STOP         = 4,
    parameter int ERASE_ON_NEWLINE = 1
) (
    input  logic                        clk_pix,
    input  logic                        rst,
    input  logic [ASCII_WIDTH-1:0]      asciiIn,
    input  logic                        dataReady,
    output logic                        wrEn,
    output logic [ADDR_WIDTH-1:0]       wrAddr,
    output logic [ASCII_WIDTH-1:0]      wrData,
    output logic [$clog2(GRID_COL)-1:0] cursorCol,
    output logic [$clog2(GRID_ROW)-1:0] cursorRow,
    output logic                        busy,
    output logic                        overflow
);
    localparam int COL_W = $clog2(GRID_COL);
    localparam int ROW_W = $clog2(GRID_ROW);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CELLS = GRID_COL * GRID_ROW;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR} state_t;

    state_t                 r_state;
    logic                   r_prev_rdy;
    logic [ASCII_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [PTR_W:0]         r_count;
    logic [ASCII_WIDTH-1:0] r_cmd;
    logic [COL_W-1:0]       r_col;
    logic [ROW_W-1:0]       r_row;
    logic [ADDR_WIDTH-1:0]  r_clr_end;
    logic                   r_wr_en;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [ASCII_WIDTH-1:0] r_wr_data;
    logic                   r_ovf;

    logic                   w_key, w_full, w_pop, w_push;
    logic [ASCII_WIDTH-1:0] w_head;
    logic                   w_head_print, w_cmd_print, w_at_home;
    logic [COL_W-1:0]       w_bs_col, w_nxt_col;
    logic [ROW_W-1:0]       w_bs_row, w_nxt_row;
    logic                   w_newline, w_ff;
    int                     w_tab;

    function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [COL_W-1:0] c,
                                                        input logic [ROW_W-1:0] r);
        return ADDR_WIDTH'(r) * ADDR_WIDTH'(GRID_COL) + ADDR_WIDTH'(c);
    endfunction

    function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
        return (r == ROW_W'(GRID_ROW - 1)) ? '0 : r + ROW_W'(1);
    endfunction

    function automatic logic is_print(input logic [ASCII_WIDTH-1:0] c);
        return (c >= ASCII_WIDTH'('h20)) && (c <= ASCII_WIDTH'('h7E));
    endfunction

    assign w_key  = dataReady & ~r_prev_rdy;
    assign w_full = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
    assign w_push = w_key && (!w_full || w_pop);
    assign w_head = r_fifo[r_rptr];

    assign w_head_print = is_print(w_head);
    assign w_cmd_print  = is_print(r_cmd);
    assign w_at_home    = (r_col == '0) && (r_row == '0);
    assign w_bs_col     = (r_col != '0) ? r_col - COL_W'(1) : COL_W'(GRID_COL - 1);
    assign w_bs_row     = (r_col != '0) ? r_row : r_row - ROW_W'(1);

    // Cursor motion decoded from the command held during EXEC.
    always_comb begin
        w_nxt_col = r_col;
        w_nxt_row = r_row;
        w_newline = 1'b0;
        w_ff      = 1'b0;
        w_tab     = (int'(r_col) / TAB_STOP + 1) * TAB_STOP;
        if (w_cmd_print) begin
            if (r_col == COL_W'(GRID_COL - 1)) w_newline = 1'b1;
            else                               w_nxt_col = r_col + COL_W'(1);
        end else if (r_cmd == ASCII_WIDTH'('h08)) begin
            if (!w_at_home) begin
                w_nxt_col = w_bs_col;
                w_nxt_row = w_bs_row;
            end
        end else if (r_cmd == ASCII_WIDTH'('h0A) || r_cmd == ASCII_WIDTH'('h0D)) begin
            w_newline = 1'b1;
        end else if (r_cmd == ASCII_WIDTH'('h09)) begin
            if (w_tab >= GRID_COL) w_newline = 1'b1;
            else                   w_nxt_col = COL_W'(w_tab);
        end else if (r_cmd == ASCII_WIDTH'('h0C)) begin
            w_ff      = 1'b1;
            w_nxt_col = '0;
            w_nxt_row = '0;
        end
        if (w_newline) begin
            w_nxt_col = '0;
            w_nxt_row = next_row(r_row);
        end
    end

    always_ff @(posedge clk_pix) begin
        if (w_push) r_fifo[r_wptr] <= asciiIn;
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_prev_rdy <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_cmd      <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_clr_end  <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_prev_rdy <= dataReady;
            r_ovf      <= w_key && !w_push;
            r_wr_en    <= 1'b0;
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (PTR_W+1)'(1);

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cmd   <= w_head;
                        r_state <= S_EXEC;
                        // The cell write is registered here so it appears during EXEC.
                        if (w_head_print) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= cell_addr(r_col, r_row);
                            r_wr_data <= w_head;
                        end else if (w_head == ASCII_WIDTH'('h08) && !w_at_home) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= cell_addr(w_bs_col, w_bs_row);
                            r_wr_data <= ASCII_WIDTH'('h20);
                        end
                    end
                end
                S_EXEC: begin
                    r_col <= w_nxt_col;
                    r_row <= w_nxt_row;
                    if (w_ff) begin
                        r_state   <= S_CLEAR;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= '0;
                        r_wr_data <= ASCII_WIDTH'('h20);
                        r_clr_end <= ADDR_WIDTH'(CELLS - 1);
                    end else if (w_newline && ERASE_ON_NEWLINE != 0) begin
                        r_state   <= S_CLEAR;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= cell_addr('0, w_nxt_row);
                        r_wr_data <= ASCII_WIDTH'('h20);
                        r_clr_end <= cell_addr('0, w_nxt_row) + ADDR_WIDTH'(GRID_COL - 1);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    if (r_wr_addr == r_clr_end) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wrEn      = r_wr_en;
    assign wrAddr    = r_wr_addr;
    assign wrData    = r_wr_data;
    assign cursorCol = r_col;
    assign cursorRow = r_row;
    assign overflow  = r_ovf;
    assign busy      = (r_state != S_IDLE) || (r_count != '0);
endmodule
